// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the 1RW memory request arbiter.
// Response entries carry read data plus out-of-range and ECC flags.
package mem_arb_pkg;

  localparam int unsigned RSP_DW = 32;

  typedef struct packed {
    logic [RSP_DW-1:0] dout;
    logic              oor;
    logic              serr;
    logic              derr;
  } rsp_entry_t;

  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_e;

  function automatic logic oor_chk(
    input logic [31:0] bank,
    input logic [31:0] addr,
    input int unsigned banks,
    input int unsigned words
  );
    return (addr >= words) || (bank >= banks);
  endfunction

endpackage

// File: rtl/mem_arb_rsp_fifo.sv
// Synchronous response FIFO with wrap-bit pointers for full/empty.
// Head entry is presented combinationally on dout.
module mem_arb_rsp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]  wptr_q, wptr_d;
  logic [PW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    dout = mem_q[rptr_q[PW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PW-1:0]] <= din;
    end
  end

  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mem_1rw_req_arb.sv
// Arbitrates independent read/write request streams onto one 1RW memory port,
// tracks read latency and returns read data in order through a credited FIFO.
module mem_1rw_req_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 32,
  parameter int unsigned BAW       = 1,
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned BANKS     = 2,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_vld,
  output logic           wr_rdy,
  input  logic [BAW-1:0] wr_bank,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_din,
  input  logic [DW-1:0]  wr_bw,
  input  logic           rd_vld,
  output logic           rd_rdy,
  input  logic [BAW-1:0] rd_bank,
  input  logic [AW-1:0]  rd_addr,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic [DW-1:0]  rsp_dout,
  output logic           rsp_oor,
  output logic           rsp_serr,
  output logic           rsp_derr,
  output logic           read_0,
  output logic           write_0,
  output logic [BAW-1:0] bank_0,
  output logic [AW-1:0]  addr_0,
  output logic [DW-1:0]  din_0,
  output logic [DW-1:0]  bw_0,
  input  logic [DW-1:0]  dout_0,
  input  logic           read_serr_0,
  input  logic           read_derr_0
);

  localparam int unsigned   CW       = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]  cnt_q, cnt_d;
  prio_e          prio_q, prio_d;
  logic           rd_ok, rd_acc, wr_acc, rd_oor, wr_oor, rsp_pop;

  logic           read_0_q, read_0_d;
  logic           write_0_q, write_0_d;
  logic [BAW-1:0] bank_0_q, bank_0_d;
  logic [AW-1:0]  addr_0_q, addr_0_d;
  logic [DW-1:0]  din_0_q, din_0_d;
  logic [DW-1:0]  bw_0_q, bw_0_d;

  logic [LATENCY:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY:0] pipe_oor_q, pipe_oor_d;

  rsp_entry_t     push_entry, head_entry;
  logic           fifo_push, fifo_full, fifo_empty;

  // Handshake and arbitration; rdy depends only on vld, cnt and prio.
  always_comb begin
    rd_oor  = oor_chk(32'(rd_bank), 32'(rd_addr), BANKS, WORDS);
    wr_oor  = oor_chk(32'(wr_bank), 32'(wr_addr), BANKS, WORDS);
    rd_ok   = (cnt_q < CNT_FULL);
    rd_rdy  = rd_ok && (!wr_vld || (prio_q == PRIO_RD));
    wr_rdy  = !(rd_vld && rd_ok && (prio_q == PRIO_RD));
    rd_acc  = rd_vld && rd_rdy;
    wr_acc  = wr_vld && wr_rdy;
    rsp_pop = !fifo_empty && rsp_rdy;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({rd_acc, rsp_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    prio_d = prio_q;
    if (rd_acc) begin
      prio_d = PRIO_WR;
    end else if (wr_acc) begin
      prio_d = PRIO_RD;
    end
  end

  // Out-of-range requests are accepted but never reach the memory port.
  always_comb begin
    read_0_d  = rd_acc && !rd_oor;
    write_0_d = wr_acc && !wr_oor;
    bank_0_d  = bank_0_q;
    addr_0_d  = addr_0_q;
    din_0_d   = din_0_q;
    bw_0_d    = bw_0_q;
    if (read_0_d) begin
      bank_0_d = rd_bank;
      addr_0_d = rd_addr;
    end else if (write_0_d) begin
      bank_0_d = wr_bank;
      addr_0_d = wr_addr;
      din_0_d  = wr_din;
      bw_0_d   = wr_bw;
    end
  end

  // Stage k is valid in cycle accept+1+k; the head lines up with memory data.
  always_comb begin
    pipe_vld_d = {pipe_vld_q[LATENCY-1:0], rd_acc};
    pipe_oor_d = {pipe_oor_q[LATENCY-1:0], rd_acc && rd_oor};
    fifo_push  = pipe_vld_q[LATENCY];
    push_entry = '0;
    push_entry.oor = pipe_oor_q[LATENCY];
    if (!pipe_oor_q[LATENCY]) begin
      push_entry.dout = dout_0;
      push_entry.serr = read_serr_0;
      push_entry.derr = read_derr_0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      prio_q     <= PRIO_RD;
      read_0_q   <= 1'b0;
      write_0_q  <= 1'b0;
      bank_0_q   <= '0;
      addr_0_q   <= '0;
      din_0_q    <= '0;
      bw_0_q     <= '0;
      pipe_vld_q <= '0;
      pipe_oor_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      read_0_q   <= read_0_d;
      write_0_q  <= write_0_d;
      bank_0_q   <= bank_0_d;
      addr_0_q   <= addr_0_d;
      din_0_q    <= din_0_d;
      bw_0_q     <= bw_0_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_oor_q <= pipe_oor_d;
    end
  end

  mem_arb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (rsp_pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response fields are forced to zero while empty so reset values hold.
  always_comb begin
    rsp_vld  = !fifo_empty;
    rsp_dout = '0;
    rsp_oor  = 1'b0;
    rsp_serr = 1'b0;
    rsp_derr = 1'b0;
    if (!fifo_empty) begin
      rsp_dout = head_entry.dout;
      rsp_oor  = head_entry.oor;
      rsp_serr = head_entry.serr;
      rsp_derr = head_entry.derr;
    end
  end

  assign read_0  = read_0_q;
  assign write_0 = write_0_q;
  assign bank_0  = bank_0_q;
  assign addr_0  = addr_0_q;
  assign din_0   = din_0_q;
  assign bw_0    = bw_0_q;

  one_strobe_a: assert property (@(posedge clk) disable iff (!rst) !(read_0_q && write_0_q));
  credit_a:     assert property (@(posedge clk) disable iff (!rst) cnt_q <= CNT_FULL);

endmodule

// File: tb/tb_mem_1rw_req_arb.sv
// Self-checking bench for mem_1rw_req_arb: behavioural memory, shadow memory
// and a response scoreboard, with one task per scenario.
module tb_mem_1rw_req_arb;

  localparam int unsigned AW        = 11;
  localparam int unsigned DW        = 32;
  localparam int unsigned BAW       = 2;
  localparam int unsigned WORDS     = 1024;
  localparam int unsigned BANKS     = 2;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned RSP_DEPTH = 8;
  localparam int unsigned NW        = BANKS * WORDS;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_vld = 1'b0, wr_rdy;
  logic [BAW-1:0] wr_bank = '0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_din = '0, wr_bw = '0;
  logic           rd_vld = 1'b0, rd_rdy;
  logic [BAW-1:0] rd_bank = '0;
  logic [AW-1:0]  rd_addr = '0;
  logic           rsp_vld, rsp_rdy = 1'b1;
  logic [DW-1:0]  rsp_dout;
  logic           rsp_oor, rsp_serr, rsp_derr;
  logic           read_0, write_0;
  logic [BAW-1:0] bank_0;
  logic [AW-1:0]  addr_0;
  logic [DW-1:0]  din_0, bw_0;
  logic [DW-1:0]  dout_0 = 'x;
  logic           read_serr_0 = 1'bx, read_derr_0 = 1'bx;

  always #5 clk = ~clk;

  mem_1rw_req_arb #(
    .AW(AW), .DW(DW), .BAW(BAW), .WORDS(WORDS), .BANKS(BANKS),
    .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_din(wr_din), .wr_bw(wr_bw),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout), .rsp_oor(rsp_oor),
    .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
    .read_0(read_0), .write_0(write_0), .bank_0(bank_0), .addr_0(addr_0),
    .din_0(din_0), .bw_0(bw_0),
    .dout_0(dout_0), .read_serr_0(read_serr_0), .read_derr_0(read_derr_0)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] dout;
    logic          oor;
    logic          serr;
    logic          derr;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] mem_model [NW];
  logic [DW+1:0] mpipe [LATENCY+1];
  logic          mpipe_v [LATENCY+1];

  function automatic logic in_range(input logic [BAW-1:0] b, input logic [AW-1:0] a);
    int unsigned bi, ai;
    bi = b;
    ai = a;
    return (bi < BANKS) && (ai < WORDS);
  endfunction

  function automatic int unsigned widx(input logic [BAW-1:0] b, input logic [AW-1:0] a);
    int unsigned bi, ai;
    bi = b;
    ai = a;
    return bi * WORDS + ai;
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural 1RW memory: a read strobed in cycle c returns data in cycle c+LATENCY.
  always @(negedge clk) begin
    for (int k = LATENCY; k > 0; k--) begin
      mpipe[k]   = mpipe[k-1];
      mpipe_v[k] = mpipe_v[k-1];
    end
    mpipe_v[0] = (read_0 === 1'b1);
    mpipe[0]   = 'x;
    if (read_0 === 1'b1 && in_range(bank_0, addr_0))
      mpipe[0] = {addr_0[1], addr_0[2], mem_model[widx(bank_0, addr_0)]};
    if (write_0 === 1'b1 && in_range(bank_0, addr_0))
      mem_model[widx(bank_0, addr_0)] =
        (mem_model[widx(bank_0, addr_0)] & ~bw_0) | (din_0 & bw_0);
    dout_0      = mpipe_v[LATENCY] ? mpipe[LATENCY][DW-1:0] : 'x;
    read_derr_0 = mpipe_v[LATENCY] ? mpipe[LATENCY][DW]     : 1'bx;
    read_serr_0 = mpipe_v[LATENCY] ? mpipe[LATENCY][DW+1]   : 1'bx;
  end

  // Monitor: command strobes vs accepts, response stability, scoreboard pops.
  logic           exp_rd = 1'b0, exp_wr = 1'b0;
  logic [BAW-1:0] exp_bank;
  logic [AW-1:0]  exp_addr;
  logic [DW-1:0]  exp_din, exp_bw;
  logic           hold = 1'b0;
  logic [DW+2:0]  hold_val;

  always @(negedge clk) begin
    exp_t e;
    logic ra, wa;
    if (!rst) begin
      sb.delete();
      exp_rd = 1'b0;
      exp_wr = 1'b0;
      hold   = 1'b0;
    end else begin
      checks++;
      if (read_0 !== exp_rd || write_0 !== exp_wr) begin
        errors++;
        $display("FAIL strobe @%0d: read_0=%b write_0=%b expected %b %b", cyc, read_0, write_0, exp_rd, exp_wr);
      end
      if (exp_rd || exp_wr) begin
        checks++;
        if (bank_0 !== exp_bank || addr_0 !== exp_addr) begin
          errors++;
          $display("FAIL cmd_addr @%0d: bank/addr=%0d/%0d expected %0d/%0d", cyc, bank_0, addr_0, exp_bank, exp_addr);
        end
      end
      if (exp_wr) begin
        checks++;
        if (din_0 !== exp_din || bw_0 !== exp_bw) begin
          errors++;
          $display("FAIL cmd_data @%0d: din/bw=%h/%h expected %h/%h", cyc, din_0, bw_0, exp_din, exp_bw);
        end
      end
      if (hold) begin
        checks++;
        if (rsp_vld !== 1'b1 || {rsp_dout, rsp_oor, rsp_serr, rsp_derr} !== hold_val) begin
          errors++;
          $display("FAIL rsp_stable @%0d: vld=%b val=%h expected 1 %h", cyc, rsp_vld,
                   {rsp_dout, rsp_oor, rsp_serr, rsp_derr}, hold_val);
        end
      end
      if (rsp_vld === 1'b1 && rsp_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected @%0d: dout=%h oor=%b, no response outstanding", cyc, rsp_dout, rsp_oor);
        end else begin
          e = sb.pop_front();
          if (rsp_dout !== e.dout || rsp_oor !== e.oor || rsp_serr !== e.serr || rsp_derr !== e.derr) begin
            errors++;
            $display("FAIL rsp_data @%0d: dout=%h oor=%b serr=%b derr=%b expected %h %b %b %b", cyc,
                     rsp_dout, rsp_oor, rsp_serr, rsp_derr, e.dout, e.oor, e.serr, e.derr);
          end
        end
      end
      hold     = (rsp_vld === 1'b1) && !rsp_rdy;
      hold_val = {rsp_dout, rsp_oor, rsp_serr, rsp_derr};

      ra = rd_vld && (rd_rdy === 1'b1);
      wa = wr_vld && (wr_rdy === 1'b1);
      if (ra && wa) begin
        checks++;
        errors++;
        $display("FAIL dual_accept @%0d: rd and wr both accepted, expected one", cyc);
      end
      exp_rd = ra && in_range(rd_bank, rd_addr);
      exp_wr = wa && !ra && in_range(wr_bank, wr_addr);
      if (exp_rd) begin
        exp_bank = rd_bank;
        exp_addr = rd_addr;
      end else if (exp_wr) begin
        exp_bank = wr_bank;
        exp_addr = wr_addr;
        exp_din  = wr_din;
        exp_bw   = wr_bw;
      end
      if (ra) begin
        if (in_range(rd_bank, rd_addr)) begin
          e.dout = ref_mem[widx(rd_bank, rd_addr)];
          e.oor  = 1'b0;
          e.serr = rd_addr[1];
          e.derr = rd_addr[2];
        end else begin
          e.dout = '0;
          e.oor  = 1'b1;
          e.serr = 1'b0;
          e.derr = 1'b0;
        end
        sb.push_back(e);
      end
      if (wa && !ra && in_range(wr_bank, wr_addr))
        ref_mem[widx(wr_bank, wr_addr)] =
          (ref_mem[widx(wr_bank, wr_addr)] & ~wr_bw) | (wr_din & wr_bw);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic do_write(input logic [BAW-1:0] b, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m, output int acc);
    wr_vld = 1'b1; wr_bank = b; wr_addr = a; wr_din = d; wr_bw = m;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_rdy === 1'b1) begin acc = cyc; break; end
    end
    @(posedge clk); #1 wr_vld = 1'b0;
  endtask

  task automatic do_read(input logic [BAW-1:0] b, input logic [AW-1:0] a, output int acc);
    rd_vld = 1'b1; rd_bank = b; rd_addr = a;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_rdy === 1'b1) begin acc = cyc; break; end
    end
    @(posedge clk); #1 rd_vld = 1'b0;
  endtask

  // Returns at the negedge where rsp_vld is first seen (or -1 after the budget).
  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_vld === 1'b1) begin rc = cyc; break; end
    end
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && rsp_vld === 1'b0) break;
    end
    checks++;
    if (sb.size() != 0 || rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, rsp_vld=%b, expected 0", sb.size(), rsp_vld);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({read_0, write_0, rsp_vld, rsp_oor, rsp_serr, rsp_derr} !== 6'b0 ||
        bank_0 !== '0 || addr_0 !== '0 || din_0 !== '0 || bw_0 !== '0 || rsp_dout !== '0) begin
      errors++;
      $display("FAIL reset_values: strobes/rsp=%b cmd=%h/%h/%h/%h dout=%h, expected all 0",
               {read_0, write_0, rsp_vld, rsp_oor, rsp_serr, rsp_derr}, bank_0, addr_0, din_0, bw_0, rsp_dout);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    int wa, ra, rc;
    do_write(2'd1, 11'd5, 32'hDEADBEEF, '1, wa);
    checks++;
    if (wa < 0) begin errors++; $display("FAIL wr_accept: timed out, expected accept"); end
    @(negedge clk);
    checks++;
    if (write_0 !== 1'b1 || cyc != wa + 1) begin
      errors++;
      $display("FAIL wr_strobe_timing: write_0=%b at cycle %0d, expected 1 at %0d", write_0, cyc, wa + 1);
    end
    @(posedge clk); #1;
    do_read(2'd1, 11'd5, ra);
    wait_rsp(rc);
    checks++;
    if (rc - ra != LATENCY + 2) begin
      errors++;
      $display("FAIL rsp_latency: rsp_vld after %0d cycles, expected %0d", rc - ra, LATENCY + 2);
    end
    checks++;
    if (rsp_dout !== 32'hDEADBEEF || rsp_oor !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_data: dout=%h oor=%b expected deadbeef 0", rsp_dout, rsp_oor);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_alternate();
    logic exp_r;
    pulse_reset();
    rd_vld = 1'b1; wr_vld = 1'b1; wr_bw = '1; rd_bank = '0; wr_bank = '0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = AW'(i);
      wr_addr = AW'(200 + i);
      wr_din  = 32'h0F000000 + i;
      @(negedge clk);
      exp_r = (i % 2 == 0);
      checks++;
      if ((rd_rdy === 1'b1) !== exp_r || (wr_rdy === 1'b1) !== !exp_r) begin
        errors++;
        $display("FAIL alternate[%0d]: rd_rdy=%b wr_rdy=%b expected %b %b", i, rd_rdy, wr_rdy, exp_r, !exp_r);
      end
      @(posedge clk); #1;
    end
    rd_vld = 1'b0; wr_vld = 1'b0;
    drain();
  endtask

  task automatic test_credit();
    int n;
    rsp_rdy = 1'b0;
    rd_vld = 1'b1; rd_bank = 2'd1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      rd_addr = AW'(300 + i);
      @(negedge clk);
      checks++;
      if (rd_rdy !== (i < 8)) begin
        errors++;
        $display("FAIL credit_rdy[%0d]: rd_rdy=%b expected %b", i, rd_rdy, (i < 8));
      end
      if (rd_rdy === 1'b1) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL credit_count: accepted %0d expected 8", n); end
    rsp_rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      rd_addr = AW'(320 + i);
      @(negedge clk);
      if (rd_rdy === 1'b1) n++;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL credit_pulse: accepted %0d expected 1", n); end
    rd_vld = 1'b0;
    drain();
  endtask

  task automatic test_oor();
    int ra, wa, nrsp;
    logic strobe;
    do_read(2'd0, 11'd1024, ra);
    do_write(2'd2, 11'd0, 32'h55555555, '1, wa);
    checks++;
    if (ra < 0 || wa < 0) begin errors++; $display("FAIL oor_accept: rd=%0d wr=%0d expected both accepted", ra, wa); end
    strobe = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read_0 !== 1'b0 || write_0 !== 1'b0) strobe = 1'b1;
      if (rsp_vld === 1'b1) begin
        nrsp++;
        checks++;
        if (rsp_oor !== 1'b1 || rsp_dout !== '0 || rsp_serr !== 1'b0 || rsp_derr !== 1'b0) begin
          errors++;
          $display("FAIL oor_rsp: oor=%b dout=%h serr=%b derr=%b expected 1 0 0 0", rsp_oor, rsp_dout, rsp_serr, rsp_derr);
        end
      end
    end
    checks++;
    if (strobe || nrsp != 1) begin
      errors++;
      $display("FAIL oor_strobes: strobe_seen=%b responses=%0d expected 0 and 1", strobe, nrsp);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_partial();
    int a, rc;
    do_write(2'd0, 11'd40, 32'hAAAAAAAA, '1, a);
    do_write(2'd0, 11'd40, 32'h12345678, 32'h0000FFFF, a);
    do_read(2'd0, 11'd40, a);
    wait_rsp(rc);
    checks++;
    if (rc < 0 || rsp_dout !== 32'hAAAA5678) begin
      errors++;
      $display("FAIL partial_write: dout=%h expected aaaa5678", rsp_dout);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_midop();
    int n;
    logic stale;
    rsp_rdy = 1'b0;
    rd_vld = 1'b1; rd_bank = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      rd_addr = AW'(500 + i);
      @(negedge clk);
      if (rd_rdy === 1'b1) n++;
      @(posedge clk); #1;
    end
    rd_vld = 1'b0;
    checks++;
    if (n != 5 || rsp_vld !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: accepted %0d rsp_vld=%b expected 5 1", n, rsp_vld);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({read_0, write_0, rsp_vld, rsp_oor, rsp_serr, rsp_derr} !== 6'b0 ||
        bank_0 !== '0 || addr_0 !== '0 || din_0 !== '0 || bw_0 !== '0 || rsp_dout !== '0) begin
      errors++;
      $display("FAIL midop_reset_values: strobes/rsp=%b cmd=%h/%h/%h/%h dout=%h, expected all 0",
               {read_0, write_0, rsp_vld, rsp_oor, rsp_serr, rsp_derr}, bank_0, addr_0, din_0, bw_0, rsp_dout);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    rsp_rdy = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_vld !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL midop_stale: rsp_vld seen after reset, expected none"); end
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    rd_vld = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      rd_addr = AW'(600 + i);
      @(negedge clk);
      if (rd_rdy === 1'b1) n++;
      @(posedge clk); #1;
    end
    rd_vld = 1'b0;
    checks++;
    if (n != 8) begin errors++; $display("FAIL midop_credit: accepted %0d expected 8", n); end
    drain();
  endtask

  initial begin
    for (int i = 0; i < int'(NW); i++) begin
      ref_mem[i]   = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      mem_model[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    end
    for (int k = 0; k <= int'(LATENCY); k++) begin
      mpipe[k]   = 'x;
      mpipe_v[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_credit();
    test_oor();
    test_partial();
    test_reset_midop();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_1rw_req_arb.md
# mem_1rw_req_arb

Request arbiter and response buffer that sits directly upstream of a single-port (1RW) banked memory. It merges an independent write-request stream and read-request stream onto the one memory port, never issuing a read and a write in the same cycle, and never issuing an out-of-range access. It tracks the fixed read latency and returns read data in order through a credit-limited response FIFO with valid/ready backpressure.

## Interface
- AW, 10, word address width
- DW, 32, data width; also the bit-enable width
- BAW, 1, bank index width (≥1)
- WORDS, 1024, words per bank
- BANKS, 2, number of banks
- LATENCY, 2, memory read latency in cycles (1..16)
- RSP_DEPTH, 8, response FIFO depth and read credit limit (power of two, ≥2)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- wr_vld / wr_rdy  in / out  1  write request handshake
- wr_bank, wr_addr, wr_din, wr_bw  in  BAW / AW / DW / DW  write bank, address, data, bit-enables
- rd_vld / rd_rdy  in / out  1  read request handshake
- rd_bank, rd_addr  in  BAW / AW  read bank and address
- rsp_vld / rsp_rdy  out / in  1  read response handshake
- rsp_dout  out  DW  read data
- rsp_oor  out  1  read was out of range; rsp_dout = 0
- rsp_serr, rsp_derr  out  1  memory single/double error flags for this read
- read_0, write_0  out  1  memory strobes (registered)
- bank_0, addr_0, din_0, bw_0  out  BAW / AW / DW / DW  memory command (registered)
- dout_0, read_serr_0, read_derr_0  in  DW / 1 / 1  memory read data and error flags

## Operation
- Transfer occurs when vld&rdy are both high at posedge. At most one request is accepted per cycle.
- Credit: cnt = reads in flight + FIFO occupancy, range 0..RSP_DEPTH. rd_ok = (cnt < RSP_DEPTH).
  - cnt +1 on read accept; −1 on response pop; unchanged when both happen.
- Arbitration, with prio flag: 0 = read favoured, 1 = write favoured.
  - rd_rdy = rd_ok & (~wr_vld | ~prio)
  - wr_rdy = ~(rd_vld & rd_ok & ~prio)
  - After a read accept, prio ← 1. After a write accept, prio ← 0. With no accept, prio holds.
- Range check: oor = (addr ≥ WORDS) | (bank ≥ BANKS).
  - Out-of-range write: accepted, then silently dropped; no write_0 is issued.
  - Out-of-range read: accepted and consumes a credit, but no read_0 is issued. The tag still travels the latency pipe and returns rsp_oor=1 with dout/serr/derr = 0.
- Latency pipe: a shift register of {valid, oor}, LATENCY+1 stages. Its head qualifies the capture of dout_0/read_serr_0/read_derr_0 into the FIFO.
- FIFO: RSP_DEPTH entries of {dout, oor, serr, derr}.
  - Write pointer and read pointer wrap modulo RSP_DEPTH, with an extra wrap bit for full/empty.
  - Overflow is impossible by credit. Pushing into a full FIFO is an assertion error.
- Reset mid-operation: in-flight tags are discarded, the FIFO is emptied, and cnt=0, prio=0.

## Timing
- Reset values: read_0=0, write_0=0, bank_0=addr_0=din_0=bw_0=0, rsp_vld=0, rsp_dout=0, rsp_oor=rsp_serr=rsp_derr=0.
- A request accepted in cycle t drives the memory command in cycle t+1, for one cycle. Strobes are otherwise 0, and command fields hold their last value.
- Read data valid from memory: cycle t+1+LATENCY. It is captured at the end of that cycle.
- rsp_vld: earliest at cycle t+2+LATENCY when the FIFO is empty. Responses are strictly in acceptance order.
- rsp_* is stable while rsp_vld=1 and rsp_rdy=0.
- Back-to-back: one request per cycle is sustainable. Reads are sustainable at full rate only while cnt < RSP_DEPTH.
- read_0 & write_0 are never both 1.
- rd_rdy/wr_rdy are combinational from vld, cnt and prio. There is no path from rdy to vld.

## Structure
- Shared package mem_arb_pkg: rsp_entry_t {dout, oor, serr, derr} and the helper function oor_chk(bank, addr).
- Sub-module mem_arb_rsp_fifo: parameterized synchronous FIFO, RSP_DEPTH × $bits(rsp_entry_t), with push/pop/full/empty. Its reset is asynchronous active-low.
- The top level holds the arbiter, credit counter, command register and latency pipe.

## Test plan
- Reset, then write 0xDEADBEEF to bank 1 addr 5 with bw all-ones, then read the same location. Required: write_0 at t+1; rsp_vld at read-accept+4 (LATENCY=2); rsp_dout=0xDEADBEEF; rsp_oor=0.
- Hold rd_vld and wr_vld high for 10 cycles with an empty FIFO. Required: accepts alternate R,W,R,W…, the first grant is a read, and read_0&write_0 is never 1.
- Hold rsp_rdy=0 and issue 12 reads. Required: exactly 8 are accepted and rd_rdy drops once cnt=8. One rsp_rdy pulse then lets exactly one more read through.
- Read bank 0 addr 1024, then write to bank 2 addr 0. Required: no memory strobe for either. One response arrives with rsp_oor=1 and rsp_dout=0.
- Partial write with bw=0x0000FFFF, din=0x12345678 over stored 0xAAAAAAAA, then a read. Required: rsp_dout=0xAAAA5678.
- Assert rst with 3 reads in flight and 2 entries in the FIFO. Required: all outputs go to their reset values immediately. After release there are no stale responses, and 8 fresh reads are accepted.
